// File: rtl/alu_cmd_sequencer.sv
// Register-file command sequencer driving an external combinational ALU.
// Loads complete in one cycle; ALU ops take one EXEC cycle, then write back and pulse done.
module alu_cmd_sequencer #(
   parameter  int N    = 8,
   parameter  int REGS = 4,
   localparam int AW   = $clog2(REGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_load,
   input  logic [3:0]    cmd_op,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW-1:0] cmd_src_a,
   input  logic [AW-1:0] cmd_src_b,
   input  logic [N-1:0]  cmd_imm,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic          alu_c_in,
   output logic [3:0]    alu_control,
   input  logic [N-1:0]  alu_result,
   input  logic          alu_c_out,
   input  logic          alu_borrow,
   input  logic          alu_zero,
   input  logic          alu_parity,
   input  logic          alu_invalid,
   input  logic [AW-1:0] rd_addr,
   output logic [N-1:0]  rd_data,
   output logic          done,
   output logic          flag_zero,
   output logic          flag_carry,
   output logic          flag_parity,
   output logic          err
);

   localparam logic [3:0] OP_ADD_C = 4'd1;
   localparam logic [3:0] OP_SUB_B = 4'd3;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t        state, state_nxt;
   logic          accept;
   logic          exec_end;
   logic [AW-1:0] dst_q;
   logic [N-1:0]  rf [REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      accept    = 1'b0;
      exec_end  = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            accept    = cmd_valid;
            if (cmd_valid && !cmd_load) state_nxt = EXEC;
         end
         EXEC: begin
            exec_end  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Loads and write-backs never share an edge: loads happen only in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REGS; i++) rf[i] <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_control <= '0;
         dst_q       <= '0;
         done        <= 1'b0;
         flag_zero   <= 1'b0;
         flag_carry  <= 1'b0;
         flag_parity <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= exec_end;
         if (accept && cmd_load) rf[cmd_dst] <= cmd_imm;
         if (accept && !cmd_load) begin
            alu_a       <= rf[cmd_src_a];
            alu_b       <= rf[cmd_src_b];
            alu_control <= cmd_op;
            dst_q       <= cmd_dst;
         end
         if (exec_end) begin
            if (alu_invalid) begin
               err <= 1'b1;
            end else begin
               rf[dst_q]   <= alu_result;
               flag_zero   <= alu_zero;
               flag_parity <= alu_parity;
               if (alu_control == OP_ADD_C)      flag_carry <= alu_c_out;
               else if (alu_control == OP_SUB_B) flag_carry <= alu_borrow;
            end
         end
      end
   end

   assign alu_c_in = flag_carry;
   assign rd_data  = rf[rd_addr];

endmodule
